letc_core_csr_ctrl: RTL and testbench

- Sequences all traffic into the core CSR file (letc_core_csrf).
- Tracks in-flight explicit CSR writes between decode and writeback, and stalls decode on CSR read-after-write hazards.
- Arbitrates the single CSR write port between writeback-stage explicit writes and an internal trap-entry sequencer, which writes mepc/mcause/mtval/mstatus.
- Sits between decode, writeback, the trap logic and letc_core_csrf.

---
 rtl/letc_core_pkg.sv | 36 +++
 rtl/letc_core_csr_sb.sv | 79 +++++++
 rtl/letc_core_csr_ctrl.sv | 135 +++++++++++++
 tb/tb_letc_core_csr_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/letc_core_pkg.sv
// Shared types and constants for the LETC core CSR control path.
// Holds the trap sequencer state encoding and the mstatus field positions.
package letc_core_pkg;

  typedef logic [11:0] csr_idx_t;
  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    TRAP_IDLE,
    TRAP_W_MEPC,
    TRAP_W_MCAUSE,
    TRAP_W_MTVAL,
    TRAP_W_MSTATUS
  } trap_state_e;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam csr_idx_t CSR_MSTATUS = 12'h300;
  localparam csr_idx_t CSR_MEPC    = 12'h341;
  localparam csr_idx_t CSR_MCAUSE  = 12'h342;
  localparam csr_idx_t CSR_MTVAL   = 12'h343;

  // mstatus on trap entry: stash MIE in MPIE, disable interrupts, enter M-mode.
  function automatic word_t trap_mstatus(word_t cur);
    word_t m;
    m                                = cur;
    m[MSTATUS_MPIE]                  = cur[MSTATUS_MIE];
    m[MSTATUS_MIE]                   = 1'b0;
    m[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return m;
  endfunction

endpackage

// File: rtl/letc_core_csr_sb.sv
// In-order scoreboard of explicit CSR writes in flight between decode and writeback.
// Reports whether a queried index is pending, whether the FIFO is full, and a sticky order error.
module letc_core_csr_sb
  import letc_core_pkg::*;
#(
  parameter int SB_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  input  logic     push,
  input  csr_idx_t push_idx,
  input  logic     pop,
  input  csr_idx_t pop_idx,
  input  csr_idx_t query_idx,
  output logic     match,
  output logic     full,
  output logic     err
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [SB_DEPTH-1:0] valid_q;
  csr_idx_t            idx_q [SB_DEPTH];
  logic [PTR_W-1:0]    head_q, tail_q;
  logic [CNT_W-1:0]    count_q;
  logic                err_q;
  logic                do_pop, do_push;

  assign full    = (count_q == CNT_W'(SB_DEPTH));
  assign do_pop  = pop && (count_q != '0);
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign err     = err_q;

  // An entry being popped this cycle still matches: there is no bypass.
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (valid_q[i] && (idx_q[i] == query_idx)) match = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (pop && ((count_q == '0) || (pop_idx != idx_q[head_q]))) err_q <= 1'b1;
      if (flush) begin
        valid_q <= '0;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        // When full with pop and push, head == tail and the later set must win.
        if (do_pop) begin
          valid_q[head_q] <= 1'b0;
          head_q          <= head_q + 1'b1;
        end
        if (do_push) begin
          valid_q[tail_q] <= 1'b1;
          tail_q          <= tail_q + 1'b1;
        end
        count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
    end
  end

  // NOTE: the index array is qualified by valid_q, so it needs no reset and stays plain storage.
  always_ff @(posedge clk) begin
    if (do_push && !flush) idx_q[tail_q] <= push_idx;
  end

endmodule

// File: rtl/letc_core_csr_ctrl.sv
// CSR traffic controller: decode RAW stall, scoreboard, and the single CSR write port
// shared by writeback (priority) and the trap-entry sequencer.
module letc_core_csr_ctrl
  import letc_core_pkg::*;
#(
  parameter int SB_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  input  logic     dec_csr_valid,
  input  csr_idx_t dec_csr_idx,
  input  logic     dec_csr_wcheck,
  input  logic     dec_issue,
  output logic     dec_stall,
  input  logic     wb_csr_wen,
  input  csr_idx_t wb_csr_widx,
  input  word_t    wb_csr_wdata,
  input  logic     trap_req,
  input  word_t    trap_pc,
  input  word_t    trap_cause,
  input  word_t    trap_tval,
  input  word_t    mstatus_cur,
  output logic     trap_busy,
  output logic     trap_done,
  output logic     csrf_wen,
  output csr_idx_t csrf_widx,
  output word_t    csrf_wdata,
  output logic     sb_err
);

  trap_state_e state_q, state_d;
  word_t       pc_q, cause_q, tval_q;
  logic        sb_match, sb_full;
  logic        trap_wen;
  csr_idx_t    trap_widx;
  word_t       trap_wdata;

  assign trap_busy = (state_q != TRAP_IDLE);
  assign dec_stall = dec_csr_valid && (sb_match || (dec_csr_wcheck && sb_full) || trap_busy);

  letc_core_csr_sb #(.SB_DEPTH(SB_DEPTH)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (dec_issue && dec_csr_wcheck && !dec_stall),
    .push_idx (dec_csr_idx),
    .pop      (wb_csr_wen),
    .pop_idx  (wb_csr_widx),
    .query_idx(dec_csr_idx),
    .match    (sb_match),
    .full     (sb_full),
    .err      (sb_err)
  );

  // NOTE: state and trap latches are sequential, so they use non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TRAP_IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      tval_q  <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == TRAP_IDLE) && trap_req) begin
        pc_q    <= trap_pc & ~word_t'(3);
        cause_q <= trap_cause;
        tval_q  <= trap_tval;
      end
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    trap_wen   = 1'b0;
    trap_widx  = '0;
    trap_wdata = '0;
    trap_done  = 1'b0;
    unique case (state_q)
      TRAP_IDLE: if (trap_req) state_d = TRAP_W_MEPC;
      TRAP_W_MEPC: begin
        trap_widx  = CSR_MEPC;
        trap_wdata = pc_q;
        if (!wb_csr_wen) begin
          trap_wen = 1'b1;
          state_d  = TRAP_W_MCAUSE;
        end
      end
      TRAP_W_MCAUSE: begin
        trap_widx  = CSR_MCAUSE;
        trap_wdata = cause_q;
        if (!wb_csr_wen) begin
          trap_wen = 1'b1;
          state_d  = TRAP_W_MTVAL;
        end
      end
      TRAP_W_MTVAL: begin
        trap_widx  = CSR_MTVAL;
        trap_wdata = tval_q;
        if (!wb_csr_wen) begin
          trap_wen = 1'b1;
          state_d  = TRAP_W_MSTATUS;
        end
      end
      TRAP_W_MSTATUS: begin
        trap_widx  = CSR_MSTATUS;
        trap_wdata = trap_mstatus(mstatus_cur);
        if (!wb_csr_wen) begin
          trap_wen  = 1'b1;
          trap_done = 1'b1;
          state_d   = TRAP_IDLE;
        end
      end
      default: state_d = TRAP_IDLE;
    endcase
  end

  // Writeback always owns the port when it writes; the sequencer simply holds.
  always_comb begin
    csrf_wen   = 1'b0;
    csrf_widx  = '0;
    csrf_wdata = '0;
    if (wb_csr_wen) begin
      csrf_wen   = 1'b1;
      csrf_widx  = wb_csr_widx;
      csrf_wdata = wb_csr_wdata;
    end else if (trap_wen) begin
      csrf_wen   = 1'b1;
      csrf_widx  = trap_widx;
      csrf_wdata = trap_wdata;
    end
  end

endmodule

// File: tb/tb_letc_core_csr_ctrl.sv
// Self-checking bench for letc_core_csr_ctrl: directed scenarios plus random traffic,
// compared against a queue-based model of pending writes and a list of trap writes.
module tb_letc_core_csr_ctrl;

  localparam int SB_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        dec_csr_valid;
  logic [11:0] dec_csr_idx;
  logic        dec_csr_wcheck;
  logic        dec_issue;
  logic        dec_stall;
  logic        wb_csr_wen;
  logic [11:0] wb_csr_widx;
  logic [31:0] wb_csr_wdata;
  logic        trap_req;
  logic [31:0] trap_pc, trap_cause, trap_tval, mstatus_cur;
  logic        trap_busy, trap_done;
  logic        csrf_wen;
  logic [11:0] csrf_widx;
  logic [31:0] csrf_wdata;
  logic        sb_err;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending write indices, sticky error, trap write step (0 = none).
  logic [11:0] sb_q[$];
  bit          m_err;
  int          trap_step;
  logic [31:0] m_pc, m_cause, m_tval;

  always #5 clk = ~clk;

  letc_core_csr_ctrl #(.SB_DEPTH(SB_DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dec_csr_valid(dec_csr_valid), .dec_csr_idx(dec_csr_idx),
    .dec_csr_wcheck(dec_csr_wcheck), .dec_issue(dec_issue), .dec_stall(dec_stall),
    .wb_csr_wen(wb_csr_wen), .wb_csr_widx(wb_csr_widx), .wb_csr_wdata(wb_csr_wdata),
    .trap_req(trap_req), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .trap_tval(trap_tval), .mstatus_cur(mstatus_cur),
    .trap_busy(trap_busy), .trap_done(trap_done),
    .csrf_wen(csrf_wen), .csrf_widx(csrf_widx), .csrf_wdata(csrf_wdata),
    .sb_err(sb_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    flush = 0; dec_csr_valid = 0; dec_csr_idx = '0; dec_csr_wcheck = 0; dec_issue = 0;
    wb_csr_wen = 0; wb_csr_widx = '0; wb_csr_wdata = '0;
    trap_req = 0; trap_pc = '0; trap_cause = '0; trap_tval = '0; mstatus_cur = '0;
  endtask

  // Check the current cycle's outputs against the model, then advance model and clock.
  task automatic cycle();
    bit          match, full, exp_stall, exp_wen, exp_done;
    logic [11:0] exp_idx;
    logic [31:0] exp_data;
    #1;
    match = 0;
    foreach (sb_q[i]) if (sb_q[i] == dec_csr_idx) match = 1;
    full      = (sb_q.size() == SB_DEPTH);
    exp_stall = dec_csr_valid && (match || (dec_csr_wcheck && full) || (trap_step != 0));
    exp_wen = 0; exp_idx = '0; exp_data = '0;
    exp_done = (trap_step == 4) && !wb_csr_wen;
    if (wb_csr_wen) begin
      exp_wen = 1; exp_idx = wb_csr_widx; exp_data = wb_csr_wdata;
    end else if (trap_step != 0) begin
      exp_wen = 1;
      case (trap_step)
        1: begin exp_idx = 12'h341; exp_data = m_pc & 32'hFFFF_FFFC; end
        2: begin exp_idx = 12'h342; exp_data = m_cause; end
        3: begin exp_idx = 12'h343; exp_data = m_tval; end
        default: begin
          exp_idx  = 12'h300;
          exp_data = (mstatus_cur & ~32'h0000_1888) | 32'h0000_1800
                   | (mstatus_cur[3] ? 32'h80 : 32'h0);
        end
      endcase
    end
    check("dec_stall", {31'b0, dec_stall}, {31'b0, exp_stall});
    check("trap_busy", {31'b0, trap_busy}, {31'b0, trap_step != 0});
    check("trap_done", {31'b0, trap_done}, {31'b0, exp_done});
    check("sb_err", {31'b0, sb_err}, {31'b0, m_err});
    check("csrf_wen", {31'b0, csrf_wen}, {31'b0, exp_wen});
    if (exp_wen) begin
      check("csrf_widx", {20'b0, csrf_widx}, {20'b0, exp_idx});
      check("csrf_wdata", csrf_wdata, exp_data);
    end
    if (wb_csr_wen) begin
      if (sb_q.size() == 0) m_err = 1;
      else begin
        if (sb_q[0] != wb_csr_widx) m_err = 1;
        void'(sb_q.pop_front());
      end
    end
    if (dec_issue && dec_csr_wcheck && !exp_stall && sb_q.size() < SB_DEPTH)
      sb_q.push_back(dec_csr_idx);
    if (flush) sb_q.delete();
    if (trap_step == 0) begin
      if (trap_req) begin
        trap_step = 1; m_pc = trap_pc; m_cause = trap_cause; m_tval = trap_tval;
      end
    end else if (!wb_csr_wen) begin
      trap_step = (trap_step == 4) ? 0 : trap_step + 1;
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    sb_q.delete(); m_err = 0; trap_step = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    model_reset();
    @(negedge clk); @(negedge clk);
    rst = 0;
  endtask

  task automatic issue_write(input logic [11:0] idx);
    idle_inputs();
    dec_csr_valid = 1; dec_csr_idx = idx; dec_csr_wcheck = 1; dec_issue = 1;
    cycle();
  endtask

  task automatic wb_write(input logic [11:0] idx, input logic [31:0] data);
    idle_inputs();
    wb_csr_wen = 1; wb_csr_widx = idx; wb_csr_wdata = data;
    cycle();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    model_reset();
    #2;
    check("rst_busy", {31'b0, trap_busy}, 32'd0);
    check("rst_wen", {31'b0, csrf_wen}, 32'd0);
    check("rst_err", {31'b0, sb_err}, 32'd0);
    check("rst_stall", {31'b0, dec_stall}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 0;

    // RAW hazard on mstatus, unrelated CSR passes.
    issue_write(12'h300);
    idle_inputs(); dec_csr_valid = 1; dec_csr_idx = 12'h300;
    #1 check("raw_stall", {31'b0, dec_stall}, 32'd1);
    cycle();
    dec_csr_idx = 12'h305;
    #1 check("raw_other", {31'b0, dec_stall}, 32'd0);
    cycle();
    dec_csr_idx = 12'h300; wb_csr_wen = 1; wb_csr_widx = 12'h300; wb_csr_wdata = 32'h55;
    #1 check("raw_pop_stall", {31'b0, dec_stall}, 32'd1);
    cycle();
    idle_inputs(); dec_csr_valid = 1; dec_csr_idx = 12'h300;
    #1 check("raw_release", {31'b0, dec_stall}, 32'd0);
    cycle();

    // Fill the scoreboard, then a writing instruction stalls even across a pop.
    for (int i = 0; i < SB_DEPTH; i++) issue_write(12'h7C0 + 12'(i));
    idle_inputs(); dec_csr_valid = 1; dec_csr_idx = 12'h7D0; dec_csr_wcheck = 1; dec_issue = 1;
    #1 check("full_stall", {31'b0, dec_stall}, 32'd1);
    cycle();
    wb_csr_wen = 1; wb_csr_widx = 12'h7C0; wb_csr_wdata = 32'h1;
    #1 check("full_pop_stall", {31'b0, dec_stall}, 32'd1);
    cycle();
    wb_csr_wen = 0;
    #1 check("full_release", {31'b0, dec_stall}, 32'd0);
    cycle();
    check("full_count", sb_q.size(), SB_DEPTH);
    for (int i = 1; i < SB_DEPTH; i++) wb_write(12'h7C0 + 12'(i), 32'(i));
    wb_write(12'h7D0, 32'h9);

    // Uncontended trap entry.
    idle_inputs();
    trap_req = 1; trap_pc = 32'h8000_0102; trap_cause = 32'h8000_000B; trap_tval = 0;
    mstatus_cur = 32'h0000_0008;
    cycle();
    trap_req = 0;
    #1 check("trap_mepc", csrf_wdata, 32'h8000_0100);
    cycle(); cycle(); cycle();
    #1 check("trap_mstatus", csrf_wdata, 32'h0000_1880);
    check("trap_done_n4", {31'b0, trap_done}, 32'd1);
    cycle();
    idle_inputs(); cycle();

    // Writeback contention during W_MCAUSE.
    issue_write(12'h7C0);
    issue_write(12'h7C1);
    idle_inputs();
    trap_req = 1; trap_pc = 32'h0000_1234; trap_cause = 32'h2; trap_tval = 32'hDEAD;
    mstatus_cur = 32'hFFFF_FFF7;
    cycle();
    trap_req = 0;
    cycle();
    wb_csr_wen = 1; wb_csr_widx = 12'h7C0; wb_csr_wdata = 32'hA0;
    cycle();
    wb_csr_widx = 12'h7C1; wb_csr_wdata = 32'hA1;
    cycle();
    wb_csr_wen = 0;
    for (int i = 0; i < 4; i++) cycle();
    check("contend_idle", {31'b0, trap_busy}, 32'd0);

    // Flush with three entries and a same-cycle push.
    for (int i = 0; i < 3; i++) issue_write(12'h340 + 12'(i));
    idle_inputs(); flush = 1;
    dec_csr_valid = 1; dec_csr_idx = 12'h350; dec_csr_wcheck = 1; dec_issue = 1;
    cycle();
    idle_inputs(); dec_csr_valid = 1; dec_csr_idx = 12'h340; dec_csr_wcheck = 1;
    #1 check("flush_no_stall", {31'b0, dec_stall}, 32'd0);
    cycle();

    // Writeback index not matching the head sets a sticky error.
    issue_write(12'h100);
    wb_write(12'h101, 32'h0);
    idle_inputs();
    for (int i = 0; i < 3; i++) cycle();
    check("err_sticky", {31'b0, sb_err}, 32'd1);

    // Reset in W_MTVAL, then a fresh trap.
    do_reset();
    idle_inputs(); trap_req = 1; trap_pc = 32'h40; trap_cause = 32'h7; trap_tval = 32'h99;
    cycle();
    trap_req = 0; cycle(); cycle();
    idle_inputs(); dec_csr_valid = 1; rst = 1;
    model_reset();
    #1;
    check("rst_mid_busy", {31'b0, trap_busy}, 32'd0);
    check("rst_mid_wen", {31'b0, csrf_wen}, 32'd0);
    check("rst_mid_stall", {31'b0, dec_stall}, 32'd0);
    check("rst_mid_err", {31'b0, sb_err}, 32'd0);
    @(negedge clk);
    rst = 0;
    idle_inputs(); trap_req = 1; trap_pc = 32'h203; trap_cause = 32'h3; trap_tval = 32'h11;
    mstatus_cur = 32'h0;
    cycle();
    trap_req = 0;
    for (int i = 0; i < 5; i++) cycle();

    // Random traffic.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      idle_inputs();
      flush          = ($urandom_range(0, 24) == 0);
      dec_csr_valid  = $urandom_range(0, 1);
      dec_csr_idx    = 12'h300 + 12'($urandom_range(0, 5));
      dec_csr_wcheck = $urandom_range(0, 1);
      dec_issue      = $urandom_range(0, 1);
      if (!flush && $urandom_range(0, 2) == 0) begin
        wb_csr_wen   = 1;
        wb_csr_widx  = (sb_q.size() > 0 && $urandom_range(0, 63) != 0) ? sb_q[0] : 12'($urandom);
        wb_csr_wdata = $urandom;
      end
      trap_req    = ($urandom_range(0, 19) == 0);
      trap_pc     = $urandom;
      trap_cause  = $urandom;
      trap_tval   = $urandom;
      mstatus_cur = $urandom;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
